// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified memory port arbiter: FSM states, port owner and defaults.
package mem_port_arbiter_pkg;

  localparam int unsigned DefaultLat = 3;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StResp
  } state_e;

  typedef enum logic {
    OwnIf,
    OwnDm
  } owner_e;

  // A LAT of 1 still needs a one-bit counter.
  function automatic int unsigned cnt_width(input int unsigned lat);
    return (lat <= 1) ? 1 : $clog2(lat);
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port fixed-latency memory between instruction fetch and data access.
// Each access holds the memory for LAT cycles, then returns registered data with a ready pulse.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned LAT    = DefaultLat,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  output logic              if_stall,
  input  logic              dm_rd_req,
  input  logic              dm_wr_req,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              dm_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned     CntW    = cnt_width(LAT);
  localparam logic [CntW-1:0] CntLast = CntW'(LAT - 1);

  state_e          state_q;
  owner_e          owner_q;
  logic [CntW-1:0] cnt_q;
  logic            flush_pend_q;
  logic            dm_req;

  assign dm_req   = dm_rd_req | dm_wr_req;
  assign if_stall = if_req & ~if_ready;
  assign dm_stall = dm_req & ~dm_ready;

  // mem_addr/mem_wdata/mem_we double as the transaction latches, so they stay put while busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      owner_q      <= OwnIf;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      if_ready     <= 1'b0;
      dm_ready     <= 1'b0;
      if_rdata     <= '0;
      dm_rdata     <= '0;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if_ready     <= 1'b0;
          dm_ready     <= 1'b0;
          flush_pend_q <= 1'b0;
          // Data side wins: the older instruction in MEM must progress first.
          if (dm_req) begin
            owner_q   <= OwnDm;
            mem_we    <= dm_wr_req;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            mem_en    <= 1'b1;
            cnt_q     <= '0;
            state_q   <= StBusy;
          end else if (if_req) begin
            owner_q   <= OwnIf;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= dm_wdata;
            mem_en    <= 1'b1;
            cnt_q     <= '0;
            state_q   <= StBusy;
          end
        end
        StBusy: begin
          if (owner_q == OwnIf && if_flush) begin
            flush_pend_q <= 1'b1;
          end
          if (cnt_q == CntLast) begin
            mem_en  <= 1'b0;
            mem_we  <= 1'b0;
            state_q <= StResp;
            if (owner_q == OwnIf) begin
              if_rdata <= mem_rdata;
              // A flush seen on this last cycle must also kill the pulse.
              if_ready <= ~(flush_pend_q | if_flush);
            end else begin
              dm_ready <= 1'b1;
              if (!mem_we) begin
                dm_rdata <= mem_rdata;
              end
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StResp: begin
          if_ready     <= 1'b0;
          dm_ready     <= 1'b0;
          flush_pend_q <= 1'b0;
          state_q      <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: two instances (LAT=3 and LAT=1) checked every cycle
// against a transaction-timing model built from grant times and fixed latency arithmetic.
module tb_mem_port_arbiter;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int          Lat0 = 3;
  localparam int          Lat1 = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req    [2];
  logic [AW-1:0] if_addr   [2];
  logic          if_flush  [2];
  logic [DW-1:0] if_rdata  [2];
  logic          if_ready  [2];
  logic          if_stall  [2];
  logic          dm_rd_req [2];
  logic          dm_wr_req [2];
  logic [AW-1:0] dm_addr   [2];
  logic [DW-1:0] dm_wdata  [2];
  logic [DW-1:0] dm_rdata  [2];
  logic          dm_ready  [2];
  logic          dm_stall  [2];
  logic          mem_en    [2];
  logic          mem_we    [2];
  logic [AW-1:0] mem_addr  [2];
  logic [DW-1:0] mem_wdata [2];
  logic [DW-1:0] mem_rdata [2];

  always #5 clk = ~clk;

  mem_port_arbiter #(.LAT(Lat0), .ADDR_W(AW), .DATA_W(DW)) u_dut_lat3 (
    .clk(clk), .rst(rst),
    .if_req(if_req[0]), .if_addr(if_addr[0]), .if_flush(if_flush[0]),
    .if_rdata(if_rdata[0]), .if_ready(if_ready[0]), .if_stall(if_stall[0]),
    .dm_rd_req(dm_rd_req[0]), .dm_wr_req(dm_wr_req[0]), .dm_addr(dm_addr[0]),
    .dm_wdata(dm_wdata[0]), .dm_rdata(dm_rdata[0]), .dm_ready(dm_ready[0]),
    .dm_stall(dm_stall[0]), .mem_en(mem_en[0]), .mem_we(mem_we[0]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
  );

  mem_port_arbiter #(.LAT(Lat1), .ADDR_W(AW), .DATA_W(DW)) u_dut_lat1 (
    .clk(clk), .rst(rst),
    .if_req(if_req[1]), .if_addr(if_addr[1]), .if_flush(if_flush[1]),
    .if_rdata(if_rdata[1]), .if_ready(if_ready[1]), .if_stall(if_stall[1]),
    .dm_rd_req(dm_rd_req[1]), .dm_wr_req(dm_wr_req[1]), .dm_addr(dm_addr[1]),
    .dm_wdata(dm_wdata[1]), .dm_rdata(dm_rdata[1]), .dm_ready(dm_ready[1]),
    .dm_stall(dm_stall[1]), .mem_en(mem_en[1]), .mem_we(mem_we[1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit model_valid = 1'b0;

  // Transaction model: grant cycle g, access busy g+1..g+lat, ready at g+lat+1.
  int            g          [2];
  int            next_idle  [2];
  bit            own_dm     [2];
  bit            m_we       [2];
  bit            flushed    [2];
  bit            just_reset [2];
  logic [AW-1:0] m_addr     [2];
  logic [DW-1:0] m_wdata    [2];
  logic [DW-1:0] e_if_rdata [2];
  logic [DW-1:0] e_dm_rdata [2];
  bit            last_if_rdy[2];
  bit            last_dm_rdy[2];
  int            obs_if     [2];
  int            obs_dm     [2];

  function automatic int lat_of(input int k);
    return (k == 0) ? Lat0 : Lat1;
  endfunction

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, act, exp);
  endtask

  function automatic string tg(input string s, input int k);
    return $sformatf("%s[lat%0d]", s, lat_of(k));
  endfunction

  task automatic eval_cycle(input int k);
    int lat;
    bit busy, resp, e_ifr, e_dmr, dm_req;
    lat    = lat_of(k);
    busy   = model_valid && cyc >= g[k] + 1 && cyc <= g[k] + lat;
    resp   = model_valid && cyc == g[k] + lat + 1;
    e_ifr  = resp && !own_dm[k] && !flushed[k];
    e_dmr  = resp && own_dm[k];
    dm_req = dm_rd_req[k] | dm_wr_req[k];
    if (if_ready[k] === 1'b1) obs_if[k] = cyc;
    if (dm_ready[k] === 1'b1) obs_dm[k] = cyc;
    if (model_valid) begin
      check(tg("mem_en", k), mem_en[k], busy);
      if (busy) begin
        check(tg("mem_we", k), mem_we[k], m_we[k]);
        check(tg("mem_addr", k), mem_addr[k], m_addr[k]);
        if (m_we[k]) check(tg("mem_wdata", k), mem_wdata[k], m_wdata[k]);
      end
      check(tg("if_ready", k), if_ready[k], e_ifr);
      check(tg("dm_ready", k), dm_ready[k], e_dmr);
      check(tg("if_rdata", k), if_rdata[k], e_if_rdata[k]);
      check(tg("dm_rdata", k), dm_rdata[k], e_dm_rdata[k]);
      check(tg("if_stall", k), if_stall[k], if_req[k] & ~e_ifr);
      check(tg("dm_stall", k), dm_stall[k], dm_req & ~e_dmr);
      if (just_reset[k]) begin
        check(tg("rst_mem_we", k), mem_we[k], 1'b0);
        check(tg("rst_mem_addr", k), mem_addr[k], '0);
        check(tg("rst_mem_wdata", k), mem_wdata[k], '0);
      end
    end
    last_if_rdy[k] = e_ifr;
    last_dm_rdy[k] = e_dmr;
    just_reset[k]  = 1'b0;
    if (rst) begin
      g[k]          = -100;
      next_idle[k]  = cyc + 1;
      flushed[k]    = 1'b0;
      e_if_rdata[k] = '0;
      e_dm_rdata[k] = '0;
      just_reset[k] = 1'b1;
    end else if (model_valid) begin
      if (busy && !own_dm[k] && if_flush[k]) flushed[k] = 1'b1;
      if (cyc == g[k] + lat) begin
        if (!own_dm[k]) e_if_rdata[k] = mem_rdata[k];
        else if (!m_we[k]) e_dm_rdata[k] = mem_rdata[k];
      end
      if (cyc >= next_idle[k] && (dm_req || if_req[k])) begin
        g[k]         = cyc;
        next_idle[k] = cyc + lat + 2;
        own_dm[k]    = dm_req;
        m_we[k]      = dm_req && dm_wr_req[k];
        m_addr[k]    = dm_req ? dm_addr[k] : if_addr[k];
        m_wdata[k]   = dm_wdata[k];
        flushed[k]   = 1'b0;
      end
    end
  endtask

  // One clock: check and advance the model mid-cycle, then step into the next cycle.
  task automatic tick();
    @(negedge clk);
    for (int k = 0; k < 2; k++) eval_cycle(k);
    if (rst) model_valid = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      mem_rdata[k] = $urandom;
      if (last_if_rdy[k]) if_req[k] = 1'b0;
      if (last_dm_rdy[k]) begin
        dm_rd_req[k] = 1'b0;
        dm_wr_req[k] = 1'b0;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_obs();
    for (int k = 0; k < 2; k++) begin
      obs_if[k] = -1000;
      obs_dm[k] = -1000;
    end
  endtask

  task automatic rand_drive(input int k);
    int sel;
    if (!if_req[k] && $urandom_range(0, 2) == 0) begin
      if_req[k]  = 1'b1;
      if_addr[k] = $urandom;
    end else if (if_req[k] && $urandom_range(0, 3) == 0) begin
      if_addr[k] = $urandom;
    end
    if_flush[k] = ($urandom_range(0, 7) == 0);
    if (if_flush[k] && if_req[k]) if_addr[k] = $urandom;
    if (!(dm_rd_req[k] || dm_wr_req[k])) begin
      if ($urandom_range(0, 3) == 0) begin
        sel          = $urandom_range(0, 2);
        dm_rd_req[k] = (sel != 1);
        dm_wr_req[k] = (sel != 0);
        dm_addr[k]   = $urandom;
        dm_wdata[k]  = $urandom;
      end
    end else if ($urandom_range(0, 3) == 0) begin
      dm_addr[k]  = $urandom;
      dm_wdata[k] = $urandom;
    end
  endtask

  int t0;

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      if_req[k] = 0; if_addr[k] = '0; if_flush[k] = 0;
      dm_rd_req[k] = 0; dm_wr_req[k] = 0; dm_addr[k] = '0; dm_wdata[k] = '0;
      mem_rdata[k] = '0; g[k] = -100; next_idle[k] = 0; just_reset[k] = 0;
      last_if_rdy[k] = 0; last_dm_rdy[k] = 0;
    end
    clear_obs();
    run(2);
    rst = 1'b0;
    run(2);

    // Plain fetch.
    clear_obs(); t0 = cyc;
    for (int k = 0; k < 2; k++) begin if_req[k] = 1; if_addr[k] = 32'h10; end
    run(8);
    for (int k = 0; k < 2; k++) check(tg("fetch_lat", k), obs_if[k] - t0, lat_of(k) + 1);

    // Simultaneous data read and fetch: data first, fetch on the next idle.
    clear_obs(); t0 = cyc;
    for (int k = 0; k < 2; k++) begin
      dm_rd_req[k] = 1; dm_addr[k] = 32'h40; if_req[k] = 1; if_addr[k] = 32'h20;
    end
    run(14);
    for (int k = 0; k < 2; k++) begin
      check(tg("prio_dm_lat", k), obs_dm[k] - t0, lat_of(k) + 1);
      check(tg("prio_if_lat", k), obs_if[k] - t0, 2 * lat_of(k) + 3);
    end

    // Write.
    clear_obs(); t0 = cyc;
    for (int k = 0; k < 2; k++) begin
      dm_wr_req[k] = 1; dm_addr[k] = 32'h80; dm_wdata[k] = 32'hDEAD_BEEF;
    end
    run(8);
    for (int k = 0; k < 2; k++) check(tg("wr_lat", k), obs_dm[k] - t0, lat_of(k) + 1);

    // Flush on the second cycle after the fetch grant, redirecting the fetch.
    clear_obs(); t0 = cyc;
    for (int k = 0; k < 2; k++) begin if_req[k] = 1; if_addr[k] = 32'h30; end
    run(2);
    for (int k = 0; k < 2; k++) begin if_flush[k] = 1; if_addr[k] = 32'h34; end
    run(1);
    for (int k = 0; k < 2; k++) if_flush[k] = 0;
    run(14);
    check(tg("flush_refetch", 0), obs_if[0] - t0, 9);
    check(tg("flush_in_resp", 1), obs_if[1] - t0, 2);

    // Reset during the access.
    clear_obs(); t0 = cyc;
    for (int k = 0; k < 2; k++) begin dm_rd_req[k] = 1; dm_addr[k] = 32'h50; end
    run(2);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    run(10);
    check(tg("rst_regrant", 0), obs_dm[0] - t0, 7);
    check(tg("rst_after_resp", 1), obs_dm[1] - t0, 2);

    // Read and write together act as a write.
    clear_obs(); t0 = cyc;
    for (int k = 0; k < 2; k++) begin
      dm_rd_req[k] = 1; dm_wr_req[k] = 1; dm_addr[k] = 32'h90; dm_wdata[k] = 32'h1234_5678;
    end
    run(8);
    for (int k = 0; k < 2; k++) check(tg("rdwr_lat", k), obs_dm[k] - t0, lat_of(k) + 1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int k = 0; k < 2; k++) rand_drive(k);
      tick();
    end
    rst = 1'b0;
    run(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
